// File: rtl/falu_result_writeback_if.sv
// FAlu result / regfile write / FCSR0 bundle between FAlu, the writeback buffer and the FP regfile.
// master drives results, acks, flush and CSR writes; slave is the writeback block.
interface falu_result_writeback_if #(
    parameter int WIDTH_FALU = 32,
    parameter int ADDR_W     = 5
);
    logic [ADDR_W-1:0]       res_addr;
    logic [WIDTH_FALU*2-1:0] res_data;
    logic                    res_vld;
    logic [WIDTH_FALU-1:0]   res_fcsr;
    logic                    res_rdy;
    logic                    flush;
    logic                    wr_en;
    logic [ADDR_W-1:0]       wr_addr;
    logic [WIDTH_FALU*2-1:0] wr_data;
    logic                    wr_ack;
    logic                    csr_wr_en;
    logic [WIDTH_FALU-1:0]   csr_wr_data;
    logic [WIDTH_FALU-1:0]   fcsr0_data;
    logic                    fp_except;

    modport master (
        output res_addr, res_data, res_vld, res_fcsr, flush, wr_ack, csr_wr_en, csr_wr_data,
        input  res_rdy, wr_en, wr_addr, wr_data, fcsr0_data, fp_except
    );

    modport slave (
        input  res_addr, res_data, res_vld, res_fcsr, flush, wr_ack, csr_wr_en, csr_wr_data,
        output res_rdy, wr_en, wr_addr, wr_data, fcsr0_data, fp_except
    );
endinterface

// File: rtl/falu_result_writeback.sv
// FAlu result buffer draining into the FP regfile write port; owns FCSR0 (optional FALU_WB_BYPASS_EN).
// Latency: push -> wr_en 1 cycle (0 with FALU_WB_BYPASS_EN on an empty buffer).
// Backpressure: res_rdy = !full, no same-cycle pop credit; head holds until wr_ack.
module falu_result_writeback #(
    parameter int WIDTH_FALU = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    falu_result_writeback_if.slave bus
);
    localparam int DW = WIDTH_FALU * 2;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [WIDTH_FALU-1:0] FCSR_MASK = WIDTH_FALU'(32'h1F1F_031F);

    logic [ADDR_W-1:0]     mem_addr  [FIFO_DEPTH];
    logic [DW-1:0]         mem_data  [FIFO_DEPTH];
    logic [4:0]            mem_cause [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count;
    logic [WIDTH_FALU-1:0] fcsr;
    logic                  except_q;

    logic                  empty, full;
    logic                  push, pop, retire;
    logic                  head_en;
    logic [ADDR_W-1:0]     head_addr;
    logic [DW-1:0]         head_data;
    logic [4:0]            ret_cause;
    logic [WIDTH_FALU-1:0] fcsr_base, fcsr_nxt;
    logic                  except_nxt;

    assign empty = (count == '0);
    assign full  = (count == CW'(FIFO_DEPTH));

    always_comb begin
        head_en   = !empty;
        head_addr = empty ? '0 : mem_addr[rd_ptr];
        head_data = empty ? '0 : mem_data[rd_ptr];
        ret_cause = mem_cause[rd_ptr];
        push      = bus.res_vld && !full && !bus.flush;
        pop       = !empty && bus.wr_ack;
        retire    = pop;
`ifdef FALU_WB_BYPASS_EN
        // Empty buffer: present the incoming result directly; an immediate ack retires it unqueued.
        if (empty && bus.res_vld) begin
            head_en   = !bus.flush;
            head_addr = bus.res_addr;
            head_data = bus.res_data;
            ret_cause = bus.res_fcsr[28:24];
            if (bus.wr_ack && !bus.flush) begin
                push   = 1'b0;
                retire = 1'b1;
            end
        end
`endif
    end

    // A CSR write replaces the base value; a same-cycle retire still layers its cause on top.
    always_comb begin
        fcsr_base  = bus.csr_wr_en ? (bus.csr_wr_data & FCSR_MASK) : fcsr;
        fcsr_nxt   = fcsr_base;
        except_nxt = 1'b0;
        if (retire) begin
            fcsr_nxt[28:24] = ret_cause;
            fcsr_nxt[20:16] = fcsr_base[20:16] | ret_cause;
            except_nxt      = |(ret_cause & fcsr_base[4:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr]  <= bus.res_addr;
            mem_data[wr_ptr]  <= bus.res_data;
            mem_cause[wr_ptr] <= bus.res_fcsr[28:24];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            fcsr     <= '0;
            except_q <= 1'b0;
        end else begin
            fcsr     <= fcsr_nxt;
            except_q <= except_nxt;
            if (bus.flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    assign bus.res_rdy    = !full;
    assign bus.wr_en      = head_en;
    assign bus.wr_addr    = head_addr;
    assign bus.wr_data    = head_data;
    assign bus.fcsr0_data = fcsr;
    assign bus.fp_except  = except_q;
endmodule

// File: tb/tb_falu_result_writeback.sv
// Directed bench for falu_result_writeback (default build, bypass disabled).
module tb_falu_result_writeback;
    localparam int W = 32;
    localparam int D = 4;
    localparam int A = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    falu_result_writeback_if #(.WIDTH_FALU(W), .ADDR_W(A)) bus ();

    falu_result_writeback #(.WIDTH_FALU(W), .FIFO_DEPTH(D), .ADDR_W(A)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic idle_inputs();
        bus.res_vld = 0; bus.res_addr = '0; bus.res_data = '0; bus.res_fcsr = '0;
        bus.flush = 0; bus.wr_ack = 0; bus.csr_wr_en = 0; bus.csr_wr_data = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #2;
        vectors++; if (bus.wr_en !== 1'b0) begin miscompares++; $display("FAIL reset_wr_en got %b want 0", bus.wr_en); end
        vectors++; if (bus.res_rdy !== 1'b1) begin miscompares++; $display("FAIL reset_rdy got %b want 1", bus.res_rdy); end
        vectors++; if (bus.fcsr0_data !== 32'h0) begin miscompares++; $display("FAIL reset_fcsr got %h want 0", bus.fcsr0_data); end
        vectors++; if (bus.fp_except !== 1'b0) begin miscompares++; $display("FAIL reset_except got %b want 0", bus.fp_except); end
        vectors++; if (bus.wr_addr !== 5'd0) begin miscompares++; $display("FAIL reset_addr got %h want 0", bus.wr_addr); end
        vectors++; if (bus.wr_data !== 64'h0) begin miscompares++; $display("FAIL reset_data got %h want 0", bus.wr_data); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_single();
        @(negedge clk);
        bus.res_vld = 1; bus.res_addr = 5'd3; bus.res_data = 64'h3F80_0000_4000_0000;
        bus.res_fcsr = '0; bus.wr_ack = 1;
        #1;
        vectors++; if (bus.wr_en !== 1'b0) begin miscompares++; $display("FAIL single_no_comb got %b want 0", bus.wr_en); end
        @(negedge clk); bus.res_vld = 0;
        vectors++; if (bus.wr_en !== 1'b1) begin miscompares++; $display("FAIL single_wr_en got %b want 1", bus.wr_en); end
        vectors++; if (bus.wr_addr !== 5'd3) begin miscompares++; $display("FAIL single_addr got %h want 3", bus.wr_addr); end
        vectors++; if (bus.wr_data !== 64'h3F80_0000_4000_0000) begin miscompares++; $display("FAIL single_data got %h want 3f80000040000000", bus.wr_data); end
        @(negedge clk);
        vectors++; if (bus.wr_en !== 1'b0) begin miscompares++; $display("FAIL single_drained got %b want 0", bus.wr_en); end
        vectors++; if (bus.res_rdy !== 1'b1) begin miscompares++; $display("FAIL single_rdy got %b want 1", bus.res_rdy); end
        bus.wr_ack = 0;
    endtask

    task automatic test_backpressure();
        bus.wr_ack = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.res_vld = 1; bus.res_addr = 5'(10 + i); bus.res_data = {32'(i), 32'hA5A5_0000}; bus.res_fcsr = '0;
        end
        @(negedge clk); bus.res_vld = 0;
        vectors++; if (bus.res_rdy !== 1'b0) begin miscompares++; $display("FAIL bp_full_rdy got %b want 0", bus.res_rdy); end
        vectors++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd10) begin miscompares++; $display("FAIL bp_head got en=%b addr=%0d want en=1 addr=10", bus.wr_en, bus.wr_addr); end
        bus.wr_ack = 1;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            vectors++; if (bus.res_rdy !== 1'b1) begin miscompares++; $display("FAIL bp_rdy_%0d got %b want 1", i, bus.res_rdy); end
            vectors++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'(10 + i) || bus.wr_data !== {32'(i), 32'hA5A5_0000})
                begin miscompares++; $display("FAIL bp_order_%0d got en=%b addr=%0d data=%h want addr=%0d", i, bus.wr_en, bus.wr_addr, bus.wr_data, 10 + i); end
        end
        @(negedge clk);
        vectors++; if (bus.wr_en !== 1'b0) begin miscompares++; $display("FAIL bp_drained got %b want 0", bus.wr_en); end
        // Streaming push+pop across the pointer wrap.
        for (int i = 0; i <= 6; i++) begin
            if (i > 0) begin
                vectors++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'(19 + i))
                    begin miscompares++; $display("FAIL wrap_%0d got en=%b addr=%0d want en=1 addr=%0d", i, bus.wr_en, bus.wr_addr, 19 + i); end
            end
            bus.res_vld = (i < 6); bus.res_addr = 5'(20 + i); bus.res_data = 64'(i);
            @(negedge clk);
        end
        vectors++; if (bus.wr_en !== 1'b0 || bus.res_rdy !== 1'b1) begin miscompares++; $display("FAIL wrap_drained got en=%b rdy=%b want 0/1", bus.wr_en, bus.res_rdy); end
        idle_inputs();
    endtask

    task automatic test_flags();
        @(negedge clk); bus.csr_wr_en = 1; bus.csr_wr_data = 32'h0000_0104;
        @(negedge clk); bus.csr_wr_en = 0;
        vectors++; if (bus.fcsr0_data !== 32'h0000_0104) begin miscompares++; $display("FAIL flags_csr got %h want 00000104", bus.fcsr0_data); end
        bus.res_vld = 1; bus.res_addr = 5'd7; bus.res_fcsr = 32'h0400_0000; bus.wr_ack = 1;
        @(negedge clk); bus.res_vld = 0;
        @(negedge clk);
        vectors++; if (bus.fcsr0_data !== 32'h0404_0104) begin miscompares++; $display("FAIL flags_set got %h want 04040104", bus.fcsr0_data); end
        vectors++; if (bus.fp_except !== 1'b1) begin miscompares++; $display("FAIL flags_except got %b want 1", bus.fp_except); end
        bus.res_vld = 1; bus.res_fcsr = 32'hE0FF_FFFF;
        @(negedge clk); bus.res_vld = 0;
        vectors++; if (bus.fp_except !== 1'b0) begin miscompares++; $display("FAIL flags_pulse got %b want 0", bus.fp_except); end
        @(negedge clk);
        vectors++; if (bus.fcsr0_data !== 32'h0004_0104) begin miscompares++; $display("FAIL flags_sticky got %h want 00040104", bus.fcsr0_data); end
        vectors++; if (bus.fp_except !== 1'b0) begin miscompares++; $display("FAIL flags_no_except got %b want 0", bus.fp_except); end
        idle_inputs();
    endtask

    task automatic test_csr_pop();
        @(negedge clk); bus.csr_wr_en = 1; bus.csr_wr_data = 32'hFFFF_FFFF;
        @(negedge clk); bus.csr_wr_en = 0;
        vectors++; if (bus.fcsr0_data !== 32'h1F1F_031F) begin miscompares++; $display("FAIL csr_mask got %h want 1f1f031f", bus.fcsr0_data); end
        bus.res_vld = 1; bus.res_addr = 5'd9; bus.res_fcsr = 32'h0100_0000; bus.wr_ack = 0;
        @(negedge clk); bus.res_vld = 0;
        bus.csr_wr_en = 1; bus.csr_wr_data = 32'h0; bus.wr_ack = 1;
        @(negedge clk); bus.csr_wr_en = 0; bus.wr_ack = 0;
        vectors++; if (bus.fcsr0_data !== 32'h0101_0000) begin miscompares++; $display("FAIL csr_pop_fcsr got %h want 01010000", bus.fcsr0_data); end
        vectors++; if (bus.fp_except !== 1'b0) begin miscompares++; $display("FAIL csr_pop_except got %b want 0", bus.fp_except); end
        vectors++; if (bus.wr_en !== 1'b0) begin miscompares++; $display("FAIL csr_pop_drained got %b want 0", bus.wr_en); end
        idle_inputs();
    endtask

    task automatic test_flush();
        bus.wr_ack = 0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            bus.res_vld = 1; bus.res_addr = 5'(i); bus.res_data = 64'(i * 16);
            bus.res_fcsr = (i == 1) ? 32'h0800_0000 : 32'h0;
        end
        @(negedge clk);
        vectors++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd1) begin miscompares++; $display("FAIL flush_head got en=%b addr=%0d want 1/1", bus.wr_en, bus.wr_addr); end
        bus.res_vld = 1; bus.res_addr = 5'd7; bus.res_fcsr = 32'h0200_0000;
        bus.flush = 1; bus.wr_ack = 1;
        @(negedge clk); idle_inputs();
        vectors++; if (bus.wr_en !== 1'b0) begin miscompares++; $display("FAIL flush_wr_en got %b want 0", bus.wr_en); end
        vectors++; if (bus.res_rdy !== 1'b1) begin miscompares++; $display("FAIL flush_rdy got %b want 1", bus.res_rdy); end
        vectors++; if (bus.fcsr0_data !== 32'h0809_0000) begin miscompares++; $display("FAIL flush_fcsr got %h want 08090000", bus.fcsr0_data); end
        @(negedge clk);
        vectors++; if (bus.wr_en !== 1'b0) begin miscompares++; $display("FAIL flush_push_dropped got %b want 0", bus.wr_en); end
    endtask

    task automatic test_reset_mid_traffic();
        bus.wr_ack = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); bus.res_vld = 1; bus.res_addr = 5'(28 + i); bus.res_data = 64'hDEAD_0000 + 64'(i);
        end
        @(negedge clk); bus.res_vld = 0;
        vectors++; if (bus.wr_en !== 1'b1) begin miscompares++; $display("FAIL mid_pre got %b want 1", bus.wr_en); end
        rst_n = 1'b0;
        #1;
        vectors++; if (bus.wr_en !== 1'b0) begin miscompares++; $display("FAIL mid_wr_en got %b want 0", bus.wr_en); end
        vectors++; if (bus.res_rdy !== 1'b1) begin miscompares++; $display("FAIL mid_rdy got %b want 1", bus.res_rdy); end
        vectors++; if (bus.fcsr0_data !== 32'h0) begin miscompares++; $display("FAIL mid_fcsr got %h want 0", bus.fcsr0_data); end
        vectors++; if (bus.wr_addr !== 5'd0 || bus.wr_data !== 64'h0) begin miscompares++; $display("FAIL mid_bus got addr=%h data=%h want 0", bus.wr_addr, bus.wr_data); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        vectors++; if (bus.wr_en !== 1'b0) begin miscompares++; $display("FAIL mid_after got %b want 0", bus.wr_en); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_flags();
        test_csr_pop();
        test_flush();
        test_reset_mid_traffic();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
